timer_tick_ctrl: RTL and testbench

//  Run/pause/clear controller and rate scheduler for the stopwatch timebase. Divides clk into 100/10/1 Hz

---
 rtl/timer_pkg.sv | 24 ++
 rtl/key_debounce.sv | 51 +++++
 rtl/timer_tick_ctrl.sv | 158 +++++++++++++++
 tb/tb_timer_tick_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the stopwatch timebase controller: FSM states, rate codes
// and prescaler sizing helpers.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam logic [1:0] RATE_1HZ     = 2'b00;
   localparam logic [1:0] RATE_10HZ    = 2'b01;
   localparam logic [1:0] RATE_1HZ_ALT = 2'b10;
   localparam logic [1:0] RATE_100HZ   = 2'b11;

   localparam int PRE_W = 19;
   localparam int DEC_W = 4;

   // Terminal count of the 100 Hz prescaler for a given input clock.
   function automatic int pre_max(input int clk_hz);
      return clk_hz / 100 - 1;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Key conditioner: 2-FF synchroniser, stable-sample counter and a one-cycle press
// pulse on each accepted released->pressed transition of an active-low key.
module key_debounce
   import timer_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYC + 1);

   logic          sync1_reg;
   logic          sync2_reg;
   logic [CW-1:0] cnt_reg;
   logic          level_reg;
   logic          press_reg;

   // The counter tracks consecutive samples that disagree with the accepted level;
   // any agreeing sample restarts the qualification window.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
         cnt_reg   <= '0;
         level_reg <= 1'b1;
         press_reg <= 1'b0;
      end else begin
         sync1_reg <= key_n;
         sync2_reg <= sync1_reg;
         press_reg <= 1'b0;
         if (sync2_reg != level_reg) begin
            if (cnt_reg == CW'(DEBOUNCE_CYC - 1)) begin
               level_reg <= sync2_reg;
               cnt_reg   <= '0;
               press_reg <= level_reg;
            end else begin
               cnt_reg <= cnt_reg + CW'(1);
            end
         end else begin
            cnt_reg <= '0;
         end
      end
   end

   assign press = press_reg;

endmodule

// File: rtl/timer_tick_ctrl.sv
// Run/pause/clear controller and 100/10/1 Hz tick scheduler for the stopwatch.
// Optional macro TIMER_CLK_OUT_EN adds the clk_timer square-wave output.
module timer_tick_ctrl
   import timer_pkg::*;
#(
   parameter int CLK_HZ       = 50_000_000,
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_start_n,
   input  logic       key_clear_n,
   input  logic       switch_1,
   input  logic       switch_2,
   output logic       tick,
   output logic       running,
   output logic       paused,
   output logic       clear_pulse,
   output logic [1:0] rate_sel
`ifdef TIMER_CLK_OUT_EN
   ,
   output logic       clk_timer
`endif
);

   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(pre_max(CLK_HZ));

   logic [1:0]       keys_n;
   logic [1:0]       press;
   logic             start_p;
   logic             clear_p;
   logic [1:0]       sw_meta_reg;
   logic [1:0]       sw_sync_reg;
   state_t           state_reg;
   state_t           state_next;
   logic [PRE_W-1:0] pre_cnt_reg;
   logic [DEC_W-1:0] dec10_reg;
   logic [DEC_W-1:0] dec1_reg;
   logic             tick_reg;
   logic             clear_pulse_reg;
   logic [1:0]       rate_sel_reg;
   logic             base;
   logic             dec10_top;
   logic             dec1_top;
   logic             hit;
   logic             rate_load;
   logic             rate_change;

   assign keys_n = {key_clear_n, key_start_n};

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_key
      key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_debounce (
         .clk   (clk),
         .rst   (rst),
         .key_n (keys_n[gi]),
         .press (press[gi])
      );
   end

   assign start_p = press[0];
   assign clear_p = press[1];

   // Clear dominates a simultaneous start.
   always_comb begin
      state_next = state_reg;
      if (clear_p) begin
         state_next = ST_IDLE;
      end else if (start_p) begin
         case (state_reg)
            ST_IDLE:  state_next = ST_RUN;
            ST_RUN:   state_next = ST_PAUSE;
            ST_PAUSE: state_next = ST_RUN;
            default:  state_next = ST_IDLE;
         endcase
      end
   end

   assign base      = (state_reg == ST_RUN) && (pre_cnt_reg == PRE_MAX);
   assign dec10_top = (dec10_reg == DEC_W'(9));
   assign dec1_top  = (dec1_reg == DEC_W'(9));

   always_comb begin
      hit = 1'b0;
      case (rate_sel_reg)
         RATE_100HZ: hit = base;
         RATE_10HZ:  hit = base && dec10_top;
         default:    hit = base && dec10_top && dec1_top;
      endcase
   end

   // Switch changes only land between periods while running, so no period is cut short.
   assign rate_load   = (state_reg != ST_RUN) || hit;
   assign rate_change = rate_load && (sw_sync_reg != rate_sel_reg);

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt_reg <= '0;
         dec10_reg   <= '0;
         dec1_reg    <= '0;
      end else if (state_reg == ST_IDLE || rate_change) begin
         pre_cnt_reg <= '0;
         dec10_reg   <= '0;
         dec1_reg    <= '0;
      end else if (base) begin
         pre_cnt_reg <= '0;
         dec10_reg   <= dec10_top ? '0 : dec10_reg + DEC_W'(1);
         if (dec10_top) begin
            dec1_reg <= dec1_top ? '0 : dec1_reg + DEC_W'(1);
         end
      end else if (state_reg == ST_RUN) begin
         pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_meta_reg     <= '0;
         sw_sync_reg     <= '0;
         state_reg       <= ST_IDLE;
         tick_reg        <= 1'b0;
         clear_pulse_reg <= 1'b0;
         rate_sel_reg    <= RATE_1HZ;
      end else begin
         sw_meta_reg     <= {switch_1, switch_2};
         sw_sync_reg     <= sw_meta_reg;
         state_reg       <= state_next;
         tick_reg        <= hit && (state_next == ST_RUN);
         clear_pulse_reg <= clear_p;
         if (rate_load) begin
            rate_sel_reg <= sw_sync_reg;
         end
      end
   end

`ifdef TIMER_CLK_OUT_EN
   logic clk_timer_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         clk_timer_reg <= 1'b0;
      end else if (state_next == ST_IDLE) begin
         clk_timer_reg <= 1'b0;
      end else if (tick_reg) begin
         clk_timer_reg <= ~clk_timer_reg;
      end
   end

   assign clk_timer = clk_timer_reg;
`endif

   assign tick        = tick_reg;
   assign running     = (state_reg == ST_RUN);
   assign paused      = (state_reg == ST_PAUSE);
   assign clear_pulse = clear_pulse_reg;
   assign rate_sel    = rate_sel_reg;

endmodule

// File: tb/tb_timer_tick_ctrl.sv
// Self-checking bench for timer_tick_ctrl: directed scenarios plus random key/switch
// activity compared every cycle against a period-counting reference model.
module tb_timer_tick_ctrl;

   localparam int CLK_HZ  = 1000;
   localparam int DB      = 4;
   localparam int PRE_MAX = CLK_HZ / 100 - 1;
   localparam int S_IDLE  = 0;
   localparam int S_RUN   = 1;
   localparam int S_PAUSE = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_start_n = 1'b1;
   logic       key_clear_n = 1'b1;
   logic       switch_1 = 1'b0;
   logic       switch_2 = 1'b0;
   logic       tick;
   logic       running;
   logic       paused;
   logic       clear_pulse;
   logic [1:0] rate_sel;
`ifdef TIMER_CLK_OUT_EN
   logic       clk_timer;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   timer_tick_ctrl #(.CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DB)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_start_n (key_start_n),
      .key_clear_n (key_clear_n),
      .switch_1    (switch_1),
      .switch_2    (switch_2),
      .tick        (tick),
      .running     (running),
      .paused      (paused),
      .clear_pulse (clear_pulse),
      .rate_sel    (rate_sel)
`ifdef TIMER_CLK_OUT_EN
      ,
      .clk_timer   (clk_timer)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: m_t counts running cycles since the current rate's phase began;
   // a period ends whenever that count is a multiple of the rate's period length.
   int         m_state = S_IDLE;
   int         m_t = 0;
   logic [1:0] m_rate = 2'b00;
   bit         m_tick = 0, m_clr_pulse = 0, m_ct = 0;
   bit         m_start_p = 0, m_clear_p = 0, m_start_lvl = 1, m_clear_lvl = 1;
   bit [DB:0]  h_start = '1, h_clear = '1;
   logic [1:0] sw_h0 = 2'b00, sw_h1 = 2'b00;

   function automatic int period(input logic [1:0] r);
      if (r == 2'b11) return PRE_MAX + 1;
      if (r == 2'b01) return 10 * (PRE_MAX + 1);
      return 100 * (PRE_MAX + 1);
   endfunction

   always @(posedge clk) begin : model
      int ns, tn;
      bit hit, load, chg;
      if (rst) begin
         m_state = S_IDLE; m_t = 0; m_rate = 2'b00;
         m_tick = 0; m_clr_pulse = 0; m_ct = 0;
         m_start_p = 0; m_clear_p = 0; m_start_lvl = 1; m_clear_lvl = 1;
         h_start = '1; h_clear = '1; sw_h0 = 2'b00; sw_h1 = 2'b00;
      end else begin
         ns = m_state;
         if (m_clear_p) ns = S_IDLE;
         else if (m_start_p) ns = (m_state == S_RUN) ? S_PAUSE : S_RUN;
         hit = 0;
         tn  = m_t;
         if (m_state == S_RUN) begin
            tn  = (m_t + 1) % (100 * (PRE_MAX + 1));
            hit = (tn % period(m_rate)) == 0;
         end
         load = (m_state != S_RUN) || hit;
         chg  = load && (sw_h1 != m_rate);
         m_t  = (m_state == S_IDLE || chg) ? 0 : tn;
         m_ct = (ns == S_IDLE) ? 1'b0 : (m_tick ? ~m_ct : m_ct);
         m_tick = hit && (ns == S_RUN);
         m_clr_pulse = m_clear_p;
         if (load) m_rate = sw_h1;
         m_state = ns;
         // A key level is accepted after DB consecutive synchronised samples disagree with it.
         m_start_p = 0;
         if (h_start[DB:1] == {DB{~m_start_lvl}}) begin
            m_start_p = m_start_lvl; m_start_lvl = ~m_start_lvl;
         end
         m_clear_p = 0;
         if (h_clear[DB:1] == {DB{~m_clear_lvl}}) begin
            m_clear_p = m_clear_lvl; m_clear_lvl = ~m_clear_lvl;
         end
         h_start = {h_start[DB-1:0], key_start_n};
         h_clear = {h_clear[DB-1:0], key_clear_n};
         sw_h1 = sw_h0;
         sw_h0 = {switch_1, switch_2};
      end
   end

   logic [6:0] obs_vec, exp_vec;
`ifdef TIMER_CLK_OUT_EN
   assign obs_vec = {clk_timer, tick, running, paused, clear_pulse, rate_sel};
   assign exp_vec = {m_ct, m_tick, m_state == S_RUN, m_state == S_PAUSE, m_clr_pulse, m_rate};
`else
   assign obs_vec = {1'b0, tick, running, paused, clear_pulse, rate_sel};
   assign exp_vec = {1'b0, m_tick, m_state == S_RUN, m_state == S_PAUSE, m_clr_pulse, m_rate};
`endif

   task automatic test_reset();
      rst = 1'b1; key_start_n = 1'b1; key_clear_n = 1'b1; {switch_1, switch_2} = 2'b00;
      for (int i = 0; i < 205; i++) begin
         @(negedge clk);
         if (i == 4) rst = 1'b0;
         n_checks++;
         if ({tick, running, clear_pulse, rate_sel} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_idle i=%0d got=%b expected=00000", i, {tick, running, clear_pulse, rate_sel});
         end
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL reset_model i=%0d got=%h expected=%h", i, obs_vec, exp_vec);
         end
      end
      $display("test_reset done");
   endtask

   task automatic test_fast_rate();
      int r = -1;
      int tk[$];
      {switch_1, switch_2} = 2'b11;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL fast_rate i=%0d got=%h expected=%h", i, obs_vec, exp_vec);
         end
         if (running === 1'b1 && r < 0) r = i;
         if (tick === 1'b1) tk.push_back(i);
         key_start_n = !(i >= 5 && i < 15);
      end
      n_checks++;
      if (r < 0 || tk.size() < 3) begin
         n_fail++;
         $display("FAIL fast_rate_seen run_at=%0d ticks=%0d expected run and >=3 ticks", r, tk.size());
      end else begin
         n_checks++;
         if (tk[0] - r != PRE_MAX + 1) begin
            n_fail++;
            $display("FAIL first_tick_latency got=%0d expected=%0d", tk[0] - r, PRE_MAX + 1);
         end
         n_checks++;
         if (tk[1] - tk[0] != PRE_MAX + 1 || tk[2] - tk[1] != PRE_MAX + 1) begin
            n_fail++;
            $display("FAIL fast_period got=%0d,%0d expected=%0d", tk[1] - tk[0], tk[2] - tk[1], PRE_MAX + 1);
         end
      end
      $display("test_fast_rate done: run_at=%0d ticks=%0d", r, tk.size());
   endtask

   task automatic test_rate_change();
      int t_prev = -1, t_a = -1, t_b = -1, chg_at = -1;
      logic [1:0] rs_a = 2'bxx;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL clear_to_idle i=%0d got=%h expected=%h", i, obs_vec, exp_vec);
         end
         key_clear_n = !(i < 6);
         if (i == 0) {switch_1, switch_2} = 2'b00;
      end
      for (int i = 0; i < 3000 && t_b < 0; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL rate_change i=%0d got=%h expected=%h", i, obs_vec, exp_vec);
         end
         if (tick === 1'b1) begin
            if (chg_at < 0) t_prev = i;
            else if (t_a < 0) begin t_a = i; rs_a = rate_sel; end
            else t_b = i;
         end
         if (t_prev >= 0 && chg_at < 0 && i == t_prev + 300) begin
            chg_at = i;
            {switch_1, switch_2} = 2'b01;
         end
         key_start_n = !(i < 6);
      end
      n_checks++;
      if (t_b < 0) begin
         n_fail++;
         $display("FAIL rate_change_ticks got prev=%0d a=%0d b=%0d expected all seen", t_prev, t_a, t_b);
      end else begin
         n_checks++;
         if (t_a - t_prev != 1000 || rs_a !== 2'b01) begin
            n_fail++;
            $display("FAIL rate_apply got gap=%0d sel=%b expected gap=1000 sel=01", t_a - t_prev, rs_a);
         end
         n_checks++;
         if (t_b - t_a != 100) begin
            n_fail++;
            $display("FAIL new_rate_period got=%0d expected=100", t_b - t_a);
         end
      end
      $display("test_rate_change done: ticks at %0d %0d %0d", t_prev, t_a, t_b);
   endtask

   task automatic test_debounce();
      int changes = 0;
      logic [1:0] prev;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL glitch i=%0d got=%h expected=%h", i, obs_vec, exp_vec);
         end
         key_start_n = !(i >= 2 && i < 5);
      end
      n_checks++;
      if ({running, paused} !== 2'b10) begin
         n_fail++;
         $display("FAIL short_press got run/pause=%b expected=10", {running, paused});
      end
      prev = {running, paused};
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL valid_press i=%0d got=%h expected=%h", i, obs_vec, exp_vec);
         end
         if ({running, paused} !== prev) changes++;
         prev = {running, paused};
         key_start_n = !(i >= 2 && i < 6);
      end
      n_checks++;
      if (changes != 1 || {running, paused} !== 2'b01) begin
         n_fail++;
         $display("FAIL one_press got changes=%0d run/pause=%b expected 1 and 01", changes, {running, paused});
      end
      $display("test_debounce done");
   endtask

   task automatic test_pause();
      int nt = 0;
      {switch_1, switch_2} = 2'b11;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL pause_resume i=%0d got=%h expected=%h", i, obs_vec, exp_vec);
         end
         n_checks++;
         if (tick === 1'b1 && paused !== 1'b0) begin
            n_fail++;
            $display("FAIL tick_in_pause i=%0d got paused=%b expected=0", i, paused);
         end
         if (tick === 1'b1) nt++;
         key_start_n = !((i % 50) >= 10 && (i % 50) < 10 + DB + 1 + (i / 50) % 3);
      end
      $display("test_pause done: ticks=%0d", nt);
   endtask

   task automatic test_clear_start();
      int cp = 0, tk_after = 0;
      bit cleared = 0;
      for (int k = 0; k < 3 && m_state != S_RUN; k++) begin
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if (obs_vec !== exp_vec) begin
               n_fail++;
               $display("FAIL enter_run i=%0d got=%h expected=%h", i, obs_vec, exp_vec);
            end
            key_start_n = !(i < 6);
         end
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL clear_start i=%0d got=%h expected=%h", i, obs_vec, exp_vec);
         end
         if (clear_pulse === 1'b1) begin cp++; cleared = 1; end
         else if (cleared && tick === 1'b1) tk_after++;
         key_start_n = !(i >= 2 && i < 8);
         key_clear_n = !(i >= 2 && i < 8);
      end
      n_checks++;
      if (cp != 1 || tk_after != 0 || {running, paused} !== 2'b00) begin
         n_fail++;
         $display("FAIL clear_wins got pulses=%0d ticks=%0d run/pause=%b expected 1,0,00",
                  cp, tk_after, {running, paused});
      end
`ifdef TIMER_CLK_OUT_EN
      n_checks++;
      if (clk_timer !== 1'b0) begin
         n_fail++;
         $display("FAIL clk_timer_idle got=%b expected=0", clk_timer);
      end
`endif
      $display("test_clear_start done: clear_pulses=%0d", cp);
   endtask

   task automatic test_random();
      int sh = 0, ch = 0, nt = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs_vec !== exp_vec) begin
            n_fail++;
            $display("FAIL random i=%0d got=%h expected=%h", i, obs_vec, exp_vec);
         end
         if (tick === 1'b1) nt++;
         if (sh == 0 && $urandom_range(0, 119) == 0) sh = $urandom_range(1, 8);
         if (ch == 0 && $urandom_range(0, 799) == 0) ch = $urandom_range(1, 8);
         key_start_n = (sh == 0);
         key_clear_n = (ch == 0);
         if (sh > 0) sh--;
         if (ch > 0) ch--;
         if ($urandom_range(0, 249) == 0) {switch_1, switch_2} = 2'($urandom_range(0, 3));
         rst = (i >= 2000 && i < 2003);
      end
      rst = 1'b0;
      $display("test_random done: ticks=%0d", nt);
   endtask

   initial begin
      test_reset();
      test_fast_rate();
      test_rate_change();
      test_debounce();
      test_pause();
      test_clear_start();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
